// File: rtl/bp_pkg.sv
// Shared back-propagation definitions: Q16.16 constants, FSM state type and
// the 2*DWIDTH -> DWIDTH narrowing used by calculate_delta2.
// Build option: define CALC_DELTA2_SAT_EN to saturate narrowings instead of wrapping.
package bp_pkg;

  localparam int unsigned DWIDTH = 32;
  localparam int unsigned FRAC   = 16;
  localparam logic [DWIDTH-1:0] ONE = DWIDTH'(1) << FRAC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Narrow a double-width signed value to DWIDTH (saturate or keep low bits)
  function automatic logic [DWIDTH-1:0] narrow(input logic [2*DWIDTH-1:0] v);
`ifdef CALC_DELTA2_SAT_EN
    logic [DWIDTH:0] hi;
    hi = v[2*DWIDTH-1:DWIDTH-1];
    if ((&hi) || (~|hi)) begin
      return v[DWIDTH-1:0];
    end else if (v[2*DWIDTH-1]) begin
      return {1'b1, {(DWIDTH-1){1'b0}}};
    end else begin
      return {1'b0, {(DWIDTH-1){1'b1}}};
    end
`else
    logic unused_hi;
    unused_hi = ^v[2*DWIDTH-1:DWIDTH];
    return v[DWIDTH-1:0];
`endif
  endfunction

endpackage

// File: rtl/bp_mac.sv
// Fixed-point multiply (Q.FRAC, arithmetic shift) feeding a double-width
// accumulator with synchronous clear.
module bp_mac #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned FRAC   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic signed [DWIDTH-1:0]   a_i,
  input  logic signed [DWIDTH-1:0]   b_i,
  output logic signed [2*DWIDTH-1:0] acc_o
);

  localparam int unsigned PW = 2 * DWIDTH;

  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] acc_d;
  logic signed [PW-1:0] acc_q;

  assign prod_c = (PW'(a_i) * PW'(b_i)) >>> FRAC;

  // Next accumulator value: clear wins over accumulate
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_c;
    end
  end

  // Accumulator register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/calculate_delta2.sv
// Hidden-layer delta stage: delta2_j = (sum_k w3[k][j]*delta3_k) * a2_j*(1-a2_j)
// in signed Q16.16. Build option: CALC_DELTA2_SAT_EN saturates both narrowings.
module calculate_delta2 #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned FRAC         = 16,
  parameter int unsigned HiddenNeuron = 16,
  parameter int unsigned x            = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DWIDTH-1:0]               w3,
  input  logic [DWIDTH-1:0]               delta3,
  input  logic [DWIDTH-1:0]               a2,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DWIDTH-1:0]               delta2,
  output logic [$clog2(HiddenNeuron)-1:0] delta2_idx,
  output logic                            done
);

  import bp_pkg::*;

  localparam int unsigned PW = 2 * DWIDTH;
  localparam int unsigned IW = $clog2(HiddenNeuron);
  localparam int unsigned KW = (x > 1) ? $clog2(x) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(x - 1);
  localparam logic [IW-1:0] J_LAST = IW'(HiddenNeuron - 1);
  localparam logic signed [DWIDTH-1:0] ONE_FX = DWIDTH'(1) << FRAC;

  state_e                     state_q;
  logic [KW-1:0]              k_q;
  logic [IW-1:0]              j_q;
  logic signed [DWIDTH-1:0]   da2_q;
  logic [DWIDTH-1:0]          delta2_q;
  logic [IW-1:0]              idx_q;
  logic                       busy_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic                       done_q;

  logic                       beat_c;
  logic                       mac_clr_c;
  logic signed [PW-1:0]       acc_w;
  logic signed [DWIDTH-1:0]   a2_s;
  logic signed [DWIDTH-1:0]   om_c;
  logic signed [PW-1:0]       da2_full_c;
  logic signed [DWIDTH-1:0]   da2_c;
  logic signed [DWIDTH-1:0]   sum_c;
  logic signed [PW-1:0]       scale_full_c;
  logic                       unused_da2_hi;

  assign beat_c    = in_valid & in_ready_q;
  // Accumulator restarts whenever a new neuron (or run) is about to begin
  assign mac_clr_c = (state_q == IDLE) | ((state_q == OUT) & out_ready);

  bp_mac #(
    .DWIDTH (DWIDTH),
    .FRAC   (FRAC)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (mac_clr_c),
    .en_i  (beat_c),
    .a_i   (w3),
    .b_i   (delta3),
    .acc_o (acc_w)
  );

  // Sigmoid derivative a2*(1-a2) and final scaling of the narrowed sum
  assign a2_s          = a2;
  assign om_c          = ONE_FX - a2_s;
  assign da2_full_c    = (PW'(a2_s) * PW'(om_c)) >>> FRAC;
  assign da2_c         = da2_full_c[DWIDTH-1:0];
  assign unused_da2_hi = ^da2_full_c[PW-1:DWIDTH];
  assign sum_c         = narrow(acc_w);
  assign scale_full_c  = (PW'(sum_c) * PW'(da2_q)) >>> FRAC;

  // Control FSM, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      j_q         <= '0;
      da2_q       <= '0;
      delta2_q    <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACC;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            k_q        <= '0;
            j_q        <= '0;
          end
        end
        ACC: begin
          if (beat_c) begin
            if (k_q == '0) begin
              da2_q <= da2_c;
            end
            if (k_q == K_LAST) begin
              state_q    <= SCALE;
              in_ready_q <= 1'b0;
              k_q        <= '0;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        SCALE: begin
          delta2_q    <= narrow(scale_full_c);
          idx_q       <= j_q;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (j_q == J_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              j_q        <= j_q + IW'(1);
              k_q        <= '0;
              in_ready_q <= 1'b1;
              state_q    <= ACC;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign delta2     = delta2_q;
  assign delta2_idx = idx_q;
  assign done       = done_q;

endmodule

// File: tb/tb_calculate_delta2.sv
// Self-checking bench for calculate_delta2 (default parameters).
module tb_calculate_delta2;

  localparam int unsigned DW = 32;
  localparam int unsigned HN = 16;
  localparam int unsigned NX = 4;

  typedef logic [DW-1:0] vec_t [NX];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] w3 = '0;
  logic [31:0] delta3 = '0;
  logic [31:0] a2 = '0;
  logic        busy;
  logic        in_ready;
  logic        out_valid;
  logic        done;
  logic [31:0] delta2;
  logic [3:0]  delta2_idx;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] exp_d_q[$];
  logic [3:0]  exp_i_q[$];

  calculate_delta2 #(
    .DWIDTH       (32),
    .FRAC         (16),
    .HiddenNeuron (16),
    .x            (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .w3         (w3),
    .delta3     (delta3),
    .a2         (a2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .delta2     (delta2),
    .delta2_idx (delta2_idx),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference narrowing (saturating build compares against signed limits)
  function automatic logic [31:0] nar(input logic signed [63:0] v);
`ifdef CALC_DELTA2_SAT_EN
    if (v > 64'sh000000007FFFFFFF) return 32'h7FFFFFFF;
    if (v < -64'sh0000000080000000) return 32'h80000000;
`endif
    return v[31:0];
  endfunction

  // Reference delta2 for one neuron
  function automatic logic [31:0] model(input vec_t wv, input vec_t dv, input logic [31:0] a);
    logic signed [63:0] acc, ws, ds, as64, om64, da2f, s64, d64, sc;
    logic signed [31:0] om, sum, da2;
    acc = 0;
    for (int k = 0; k < NX; k++) begin
      ws = {{32{wv[k][31]}}, wv[k]};
      ds = {{32{dv[k][31]}}, dv[k]};
      acc = acc + ((ws * ds) >>> 16);
    end
    om   = 32'sh00010000 - $signed(a);
    as64 = {{32{a[31]}}, a};
    om64 = {{32{om[31]}}, om};
    da2f = (as64 * om64) >>> 16;
    da2  = da2f[31:0];
    sum  = nar(acc);
    s64  = {{32{sum[31]}}, sum};
    d64  = {{32{da2[31]}}, da2};
    sc   = (s64 * d64) >>> 16;
    return nar(sc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present nbeats input beats; a2 carries junk except on beat 0
  task automatic drive_neuron(input vec_t wv, input vec_t dv, input logic [31:0] a,
                              input bit gaps, input int nbeats);
    int n;
    for (int k = 0; k < nbeats; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      w3 = wv[k];
      delta3 = dv[k];
      a2 = (k == 0) ? a : $urandom();
      in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
        tick();
        n++;
      end
      if (in_ready !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL beat_accept k=%0d in_ready=%b want 1", k, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (delta2 !== 32'h0) begin errors++; $display("FAIL rst_delta2 got %h want 0", delta2); end
    checks++; if (delta2_idx !== 4'h0) begin errors++; $display("FAIL rst_idx got %0d want 0", delta2_idx); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    vec_t wv, dv;
    logic [31:0] ed;
    logic [3:0] ei;
    int cyc, d0;
    wv = '{default: 32'h00010000};
    dv = '{default: 32'h00004000};
    d0 = done_cnt;
    start_run();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL nom_start busy=%b in_ready=%b want 1/1", busy, in_ready);
    end
    for (int j = 0; j < HN; j++) begin
      exp_d_q.push_back(32'h00004000);
      exp_i_q.push_back(4'(j));
      drive_neuron(wv, dv, 32'h00008000, 1'b0, NX);
      if (j == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL nom_scale_cycle out_valid=%b want 0", out_valid); end
      end
      wait_valid(cyc);
      if (j == 0) begin
        checks++;
        if (cyc != 1) begin errors++; $display("FAIL nom_latency cycles=%0d want 1", cyc); end
      end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL nom_valid j=%0d out_valid=%b want 1", j, out_valid);
      end else begin
        ed = exp_d_q.pop_front();
        ei = exp_i_q.pop_front();
        checks++;
        if (delta2 !== ed || delta2_idx !== ei) begin
          errors++; $display("FAIL nom_data j=%0d got %h/%0d want %h/%0d", j, delta2, delta2_idx, ed, ei);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (j != HN - 1) begin
          checks++;
          if (done !== 1'b0) begin errors++; $display("FAIL nom_early_done j=%0d done=%b want 0", j, done); end
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL nom_done done=%b busy=%b want 1/0", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL nom_done_pulse done=%b want 0", done); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL nom_done_count got %0d want 1", done_cnt - d0); end
  endtask

  // Table of value scenarios: negative, overflow, random vectors
  task automatic test_values();
    vec_t wv, dv;
    logic [31:0] a, e, ed;
    logic [3:0] ei;
    int cyc;
    for (int s = 0; s < 3; s++) begin
      start_run();
      for (int j = 0; j < HN; j++) begin
        if (s == 0) begin
          wv = '{default: 32'hFFFF0000}; dv = '{default: 32'h00008000}; a = 32'h00008000;
          e = 32'hFFFF8000;
        end else if (s == 1) begin
          wv = '{default: 32'h01000000}; dv = '{default: 32'h01000000}; a = 32'h00008000;
`ifdef CALC_DELTA2_SAT_EN
          e = 32'h1FFFFFFF;
`else
          e = 32'h00000000;
`endif
        end else begin
          for (int k = 0; k < NX; k++) begin
            wv[k] = $urandom();
            dv[k] = $urandom();
          end
          a = $urandom();
          e = model(wv, dv, a);
        end
        exp_d_q.push_back(e);
        exp_i_q.push_back(4'(j));
        drive_neuron(wv, dv, a, s == 2, NX);
        wait_valid(cyc);
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL val%0d_valid j=%0d out_valid=%b want 1", s, j, out_valid);
        end else begin
          ed = exp_d_q.pop_front();
          ei = exp_i_q.pop_front();
          checks++;
          if (delta2 !== ed || delta2_idx !== ei) begin
            errors++; $display("FAIL val%0d_data j=%0d got %h/%0d want %h/%0d", s, j, delta2, delta2_idx, ed, ei);
          end
          out_ready = 1'b1;
          tick();
          out_ready = 1'b0;
        end
      end
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL val%0d_done done=%b want 1", s, done); end
      tick();
    end
  endtask

  task automatic test_stall();
    vec_t wv, dv;
    logic [31:0] ed;
    logic [3:0] ei;
    int cyc;
    wv = '{default: 32'h00010000};
    dv = '{default: 32'h00004000};
    start_run();
    for (int j = 0; j < HN; j++) begin
      exp_d_q.push_back(32'h00004000);
      exp_i_q.push_back(4'(j));
      drive_neuron(wv, dv, 32'h00008000, 1'b1, NX);
      wait_valid(cyc);
      if (j == 3 && out_valid === 1'b1) begin
        in_valid = 1'b1;
        w3 = $urandom();
        delta3 = $urandom();
        for (int s = 0; s < 5; s++) begin
          checks++;
          if (delta2 !== 32'h00004000 || delta2_idx !== 4'd3 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d got %h/%0d v=%b rdy=%b want 00004000/3 v=1 rdy=0",
                     s, delta2, delta2_idx, out_valid, in_ready);
          end
          tick();
        end
        in_valid = 1'b0;
      end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL stall_valid j=%0d out_valid=%b want 1", j, out_valid);
      end else begin
        ed = exp_d_q.pop_front();
        ei = exp_i_q.pop_front();
        checks++;
        if (delta2 !== ed || delta2_idx !== ei) begin
          errors++; $display("FAIL stall_data j=%0d got %h/%0d want %h/%0d", j, delta2, delta2_idx, ed, ei);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL stall_done done=%b want 1", done); end
    tick();
  endtask

  task automatic test_reset_midrun();
    vec_t wv, dv;
    logic [31:0] ed;
    logic [3:0] ei;
    int cyc, d0;
    wv = '{default: 32'h00010000};
    dv = '{default: 32'h00004000};
    start_run();
    for (int j = 0; j < 3; j++) begin
      if (j == 1) start_run();
      exp_d_q.push_back(32'h00004000);
      exp_i_q.push_back(4'(j));
      drive_neuron(wv, dv, 32'h00008000, 1'b0, NX);
      wait_valid(cyc);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL mid_valid j=%0d out_valid=%b want 1", j, out_valid);
      end else begin
        ed = exp_d_q.pop_front();
        ei = exp_i_q.pop_front();
        checks++;
        if (delta2 !== ed || delta2_idx !== ei) begin
          errors++; $display("FAIL mid_data j=%0d got %h/%0d want %h/%0d", j, delta2, delta2_idx, ed, ei);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
    end
    drive_neuron(wv, dv, 32'h00008000, 1'b0, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 ||
        delta2 !== 32'h0 || delta2_idx !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset busy=%b rdy=%b v=%b done=%b d=%h idx=%0d want all 0",
               busy, in_ready, out_valid, done, delta2, delta2_idx);
    end
    in_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL idle_no_accept rdy=%b busy=%b want 0/0", in_ready, busy);
      end
    end
    in_valid = 1'b0;
    exp_d_q.delete();
    exp_i_q.delete();
    d0 = done_cnt;
    start_run();
    for (int j = 0; j < HN; j++) begin
      exp_d_q.push_back(32'h00004000);
      exp_i_q.push_back(4'(j));
      drive_neuron(wv, dv, 32'h00008000, 1'b0, NX);
      wait_valid(cyc);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL rerun_valid j=%0d out_valid=%b want 1", j, out_valid);
      end else begin
        ed = exp_d_q.pop_front();
        ei = exp_i_q.pop_front();
        checks++;
        if (delta2 !== ed || delta2_idx !== ei) begin
          errors++; $display("FAIL rerun_data j=%0d got %h/%0d want %h/%0d", j, delta2, delta2_idx, ed, ei);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
    end
    tick();
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL rerun_done_count got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_values();
    test_stall();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calculate_delta2.md
# calculate_delta2

Hidden-layer error back-propagation stage of the training datapath. It consumes the output-layer deltas (delta3) together with the matching output-layer weights, and computes one hidden-layer delta per hidden neuron. Each result is delta2_j = (Σ_k w3[k][j]·delta3_k) · a2_j·(1−a2_j). It sits directly downstream of the output-delta stage and feeds the weight-update stage through a valid/ready output.

## Interface
Parameters:
- DWIDTH, 32, data word width; signed Q16.16 fixed point.
- FRAC, 16, fractional bits.
- HiddenNeuron, 16, number of hidden neurons (deltas produced per run).
- x, 4, number of output neurons (input beats per hidden neuron).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse that begins a run; ignored unless idle.
- busy  out  1  high from the start acceptance until done.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat.
- w3  in  DWIDTH  weight w3[k][j].
- delta3  in  DWIDTH  output delta k.
- a2  in  DWIDTH  hidden activation j; sampled only on beat k=0.
- out_valid  out  1  delta2 valid.
- out_ready  in  1  consumer accepts delta2.
- delta2  out  DWIDTH  hidden delta.
- delta2_idx  out  $clog2(HiddenNeuron)  index j of delta2.
- done  out  1  one-cycle pulse after the last delta2 handshake.

## Operation
- States: IDLE, ACC, SCALE, OUT.
- IDLE:
  - start=1 → ACC, with acc=0, k=0, j=0.
- ACC:
  - in_ready=1.
  - Each accepted beat (in_valid&in_ready): prod = (w3·delta3) as a 2·DWIDTH signed product, arithmetic-shifted right by FRAC; acc += prod (2·DWIDTH accumulator).
  - On k=0, also register da2 = (a2·(ONE−a2))>>>FRAC, where ONE=1<<FRAC.
  - Then k++.
  - Beat with k=x−1 → SCALE.
- SCALE (1 cycle):
  - sum = acc narrowed to DWIDTH (low bits, i.e. wrap).
  - delta2 ← (sum·da2)>>>FRAC truncated to DWIDTH.
  - delta2_idx ← j.
  - → OUT.
- OUT:
  - out_valid=1; delta2 and delta2_idx held stable.
  - On out_ready: if j=HiddenNeuron−1 → IDLE with done=1 for one cycle; else j++, k=0, acc=0 → ACC.
- in_ready=0 in every state except ACC. Beats presented at other times are not consumed.
- start while busy: ignored, no effect.
- Product shifts are arithmetic (toward −∞).

## Timing
- Reset values (any cycle rst_n=0, including mid-run):
  - state=IDLE; acc, k, j, da2 = 0.
  - busy, in_ready, out_valid, done = 0.
  - delta2=0, delta2_idx=0.
  - No partial results survive.
- busy rises the cycle after start is sampled.
- Latency: last beat accepted at edge T; SCALE during cycle T+1; out_valid high from cycle T+2.
- Throughput: one beat per cycle in ACC. Per neuron: x + 2 cycles minimum (plus output stall).
- Backpressure: while out_ready=0, outputs hold and no new beats are accepted.
- Gaps in in_valid stall ACC without changing state.
- done and busy fall coincide: done pulses in the first IDLE cycle, where busy=0.

## Configuration
- CALC_DELTA2_SAT_EN defined:
  - Narrowing of acc to DWIDTH saturates to 0x7FFFFFFF / 0x80000000.
  - The final delta2 truncation saturates likewise.
- Undefined: both narrowings wrap (keep low DWIDTH bits).

## Structure
- Shared package bp_pkg:
  - DWIDTH, FRAC, ONE constants.
  - State enum typedef (IDLE, ACC, SCALE, OUT).
  - Saturate/narrow function guarded by CALC_DELTA2_SAT_EN.
- One sub-module: bp_mac (fixed-point multiply-shift plus 2·DWIDTH accumulate with clear). Top level holds the FSM, counters and output register.

## Test plan
- Nominal run: w3=0x00010000, delta3=0x00004000, a2=0x00008000 for all beats → 16 outputs delta2=0x00004000, delta2_idx 0..15 in order, a single done pulse.
- Negative values: w3=0xFFFF0000, delta3=0x00008000, a2=0x00008000 → every delta2=0xFFFF8000.
- Stalls: random in_valid gaps plus out_ready low 5 cycles on neuron 3.
  - Results are identical to the nominal run.
  - delta2 is held stable during the stall.
  - in_ready=0 during the stall.
- Overflow: w3=delta3=0x01000000, a2=0x00008000.
  - With CALC_DELTA2_SAT_EN: delta2=0x1FFFFFFF.
  - Without it: delta2=0x00000000.
- Reset mid-run: rst_n low for one cycle during ACC of neuron 3.
  - All outputs are zero next cycle; state is IDLE.
  - A fresh start then reproduces the nominal results exactly.
  - A start pulsed during the run is ignored.
